sms_clk_enable_gen: RTL and testbench

- Fractional-N clock-enable generator that consumes the 74.25 MHz PLL pixel clock.
- Does in logic the reverse of the PLL: where the PLL multiplies the board clock up, this block divides the fabric clock down to the SMS master-clock rate with a phase accumulator.
- Derives single-cycle enables for the VDP, Z80 CPU and PSG from that master rate.
- Sits at the top of the console core. All console logic runs on clk gated by these enables.

---
 rtl/sms_clk_enable_gen.sv | 126 ++++++++++++
 tb/tb_sms_clk_enable_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sms_clk_enable_gen.sv
// Fractional-N clock-enable generator: a phase accumulator divides clk down to the SMS master
// rate, and counters derive single-cycle VDP, Z80 and PSG enables from the master ticks.
module sms_clk_enable_gen #(
  parameter int unsigned       ACC_W       = 32,
  parameter logic [ACC_W-1:0]  DEFAULT_INC = 32'd3105864386,
  parameter int unsigned       VDP_DIV     = 10,
  parameter int unsigned       CPU_DIV     = 15,
  parameter int unsigned       PSG_DIV     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pause,
  input  logic [ACC_W-1:0] inc_in,
  input  logic             inc_valid,
  output logic             inc_ready,
  output logic             ce_mclk,
  output logic             ce_vdp,
  output logic             ce_cpu,
  output logic             ce_psg
);

  localparam int unsigned VW = $clog2(VDP_DIV);
  localparam int unsigned CW = $clog2(CPU_DIV);
  localparam int unsigned PW = $clog2(PSG_DIV);
  localparam logic [VW-1:0] VdpLast = VW'(VDP_DIV - 1);
  localparam logic [CW-1:0] CpuLast = CW'(CPU_DIV - 1);
  localparam logic [PW-1:0] PsgLast = PW'(PSG_DIV - 1);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] inc_q, inc_d;
  logic [ACC_W-1:0] pend_inc_q, pend_inc_d;
  logic             pend_q, pend_d;
  logic [VW-1:0]    vdp_cnt_q, vdp_cnt_d;
  logic [CW-1:0]    cpu_cnt_q, cpu_cnt_d;
  logic [PW-1:0]    psg_cnt_q, psg_cnt_d;
  logic             ready_q, ready_d;
  logic             ce_mclk_q, ce_mclk_d;
  logic             ce_vdp_q, ce_vdp_d;
  logic             ce_cpu_q, ce_cpu_d;
  logic             ce_psg_q, ce_psg_d;

  logic [ACC_W:0]   sum;
  logic             tick;
  logic             vdp_wrap, cpu_wrap, psg_wrap;
  logic             commit, xfer;

  always_comb begin
    sum      = {1'b0, acc_q} + {1'b0, inc_q};
    // A paused cycle never produces a master tick, so nothing downstream advances.
    tick     = sum[ACC_W] & ~pause;
    vdp_wrap = (vdp_cnt_q == VdpLast);
    cpu_wrap = (cpu_cnt_q == CpuLast);
    psg_wrap = (psg_cnt_q == PsgLast);
    // Swap the increment only on the common VDP/CPU wrap so enable phases stay coherent.
    commit   = pend_q & tick & vdp_wrap & cpu_wrap;
    xfer     = inc_valid & ready_q;

    acc_d      = acc_q;
    inc_d      = inc_q;
    pend_inc_d = pend_inc_q;
    pend_d     = pend_q;
    vdp_cnt_d  = vdp_cnt_q;
    cpu_cnt_d  = cpu_cnt_q;
    psg_cnt_d  = psg_cnt_q;

    if (!pause) acc_d = sum[ACC_W-1:0];

    if (tick) begin
      vdp_cnt_d = vdp_wrap ? '0 : vdp_cnt_q + VW'(1);
      cpu_cnt_d = cpu_wrap ? '0 : cpu_cnt_q + CW'(1);
      if (cpu_wrap) psg_cnt_d = psg_wrap ? '0 : psg_cnt_q + PW'(1);
    end

    ce_mclk_d = tick;
    ce_vdp_d  = tick & vdp_wrap;
    ce_cpu_d  = tick & cpu_wrap;
    ce_psg_d  = tick & cpu_wrap & psg_wrap;

    if (commit) begin
      inc_d  = pend_inc_q;
      pend_d = 1'b0;
    end
    if (xfer) begin
      pend_inc_d = inc_in;
      pend_d     = 1'b1;
    end
    ready_d = ~pend_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q      <= '0;
      inc_q      <= DEFAULT_INC;
      pend_inc_q <= '0;
      pend_q     <= 1'b0;
      vdp_cnt_q  <= '0;
      cpu_cnt_q  <= '0;
      psg_cnt_q  <= '0;
      ready_q    <= 1'b0;
      ce_mclk_q  <= 1'b0;
      ce_vdp_q   <= 1'b0;
      ce_cpu_q   <= 1'b0;
      ce_psg_q   <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      inc_q      <= inc_d;
      pend_inc_q <= pend_inc_d;
      pend_q     <= pend_d;
      vdp_cnt_q  <= vdp_cnt_d;
      cpu_cnt_q  <= cpu_cnt_d;
      psg_cnt_q  <= psg_cnt_d;
      ready_q    <= ready_d;
      ce_mclk_q  <= ce_mclk_d;
      ce_vdp_q   <= ce_vdp_d;
      ce_cpu_q   <= ce_cpu_d;
      ce_psg_q   <= ce_psg_d;
    end
  end

  assign inc_ready = ready_q;
  assign ce_mclk   = ce_mclk_q;
  assign ce_vdp    = ce_vdp_q;
  assign ce_cpu    = ce_cpu_q;
  assign ce_psg    = ce_psg_q;

endmodule

// File: tb/tb_sms_clk_enable_gen.sv
// Bench for sms_clk_enable_gen: hand vectors, directed rate/handshake/pause sequences and
// random stimulus, all checked against a phase-total / tick-index reference model.
module tb_sms_clk_enable_gen;

  localparam logic [31:0] DEF = 32'd3105864386;

  logic        clk = 1'b0;
  logic        reset, pause, inc_valid;
  logic [31:0] inc_in;
  logic        inc_ready, ce_mclk, ce_vdp, ce_cpu, ce_psg;

  always #5 clk = ~clk;

  sms_clk_enable_gen dut (
    .clk       (clk),
    .reset     (reset),
    .pause     (pause),
    .inc_in    (inc_in),
    .inc_valid (inc_valid),
    .inc_ready (inc_ready),
    .ce_mclk   (ce_mclk),
    .ce_vdp    (ce_vdp),
    .ce_cpu    (ce_cpu),
    .ce_psg    (ce_psg)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: total phase ever added, and the index of master ticks since reset.
  longint unsigned m_phase, m_inc, m_pend_inc, m_n;
  bit              m_pend, m_ready;
  logic [4:0]      m_out;  // {mclk, vdp, cpu, psg, ready}

  int cnt_mclk, cnt_vdp, cnt_cpu, cnt_psg, cnt_orphan;

  function automatic void model_edge();
    longint unsigned nph;
    bit t, xfer, commit;
    logic [3:0] ce;
    ce = 4'b0;
    if (reset) begin
      m_phase = 0; m_n = 0; m_inc = 64'(DEF); m_pend = 0; m_pend_inc = 0; m_ready = 0;
    end else begin
      xfer   = inc_valid && m_ready;
      commit = 0;
      if (!pause) begin
        nph = m_phase + m_inc;
        t   = (nph >> 32) != (m_phase >> 32);
        m_phase = nph;
        if (t) begin
          m_n++;
          ce = {1'b1, m_n % 10 == 0, m_n % 15 == 0, m_n % 240 == 0};
          commit = m_pend && (m_n % 30 == 0);
        end
      end
      if (commit) begin
        m_inc  = m_pend_inc;
        m_pend = 0;
      end
      if (xfer) begin
        m_pend     = 1;
        m_pend_inc = 64'(inc_in);
      end
      m_ready = !m_pend;
    end
    m_out = {ce, m_ready};
  endfunction

  task automatic step();
    logic [4:0] got;
    @(posedge clk);
    model_edge();
    #1;
    got = {ce_mclk, ce_vdp, ce_cpu, ce_psg, inc_ready};
    checks++;
    if (got !== m_out) begin
      errors++;
      $display("FAIL model_step t=%0t got=%b expected=%b", $time, got, m_out);
    end
    cnt_mclk   += int'(ce_mclk);
    cnt_vdp    += int'(ce_vdp);
    cnt_cpu    += int'(ce_cpu);
    cnt_psg    += int'(ce_psg);
    cnt_orphan += int'((ce_vdp | ce_cpu | ce_psg) & ~ce_mclk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_counts();
    cnt_mclk = 0; cnt_vdp = 0; cnt_cpu = 0; cnt_psg = 0; cnt_orphan = 0;
  endtask

  task automatic chk(input string nm, input longint got, input longint lo, input longint hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d..%0d", nm, got, lo, hi);
    end
  endtask

  task automatic wait_ready(input string nm, input int maxc);
    int k = 0;
    while (!inc_ready && k < maxc) begin
      step();
      k++;
    end
    chk(nm, longint'(inc_ready), 1, 1);
  endtask

  task automatic program_inc(input logic [31:0] v);
    inc_valid = 1'b1;
    inc_in    = v;
    step();
    inc_valid = 1'b0;
  endtask

  typedef struct {
    bit         rst;
    bit         pse;
    bit         vld;
    logic [31:0] inc;
    logic [4:0] exp_out;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // Hand-derived from DEF: acc sequence 0, DEF, 2DEF-2^32, ... (carry on edges 2,3,5,7).
    tbl[0]  = '{1, 0, 0, 32'h0,        5'b00000};
    tbl[1]  = '{0, 0, 0, 32'h0,        5'b00001};
    tbl[2]  = '{0, 0, 0, 32'h0,        5'b10001};
    tbl[3]  = '{0, 0, 0, 32'h0,        5'b10001};
    tbl[4]  = '{0, 0, 0, 32'h0,        5'b00001};
    tbl[5]  = '{0, 0, 0, 32'h0,        5'b10001};
    tbl[6]  = '{0, 1, 0, 32'h0,        5'b00001};
    tbl[7]  = '{0, 0, 0, 32'h0,        5'b10001};
    tbl[8]  = '{1, 0, 1, 32'h8000_0000, 5'b00000};
    tbl[9]  = '{0, 0, 1, 32'h8000_0000, 5'b00001};
    tbl[10] = '{0, 0, 1, 32'h8000_0000, 5'b10000};

    reset = 1'b1; pause = 1'b0; inc_valid = 1'b0; inc_in = '0;
    m_out = '0;
    clear_counts();

    for (int i = 0; i < 11; i++) begin
      reset = tbl[i].rst; pause = tbl[i].pse; inc_valid = tbl[i].vld; inc_in = tbl[i].inc;
      step();
      chk($sformatf("vec%0d", i), longint'({ce_mclk, ce_vdp, ce_cpu, ce_psg, inc_ready}),
          longint'(tbl[i].exp_out), longint'(tbl[i].exp_out));
    end

    // Pending 2^31; a different value offered while not ready must be ignored.
    inc_valid = 1'b1; inc_in = 32'h0;
    wait_ready("commit_ready", 200);
    chk("commit_on_wrap", longint'({ce_vdp, ce_cpu}), 3, 3);
    inc_valid = 1'b0;

    // Rate at inc = 2^31.
    step();
    clear_counts();
    run(480);
    chk("half_mclk", cnt_mclk, 240, 240);
    chk("half_vdp", cnt_vdp, 24, 24);
    chk("half_cpu", cnt_cpu, 16, 16);
    chk("half_psg", cnt_psg, 1, 1);
    chk("coincide", cnt_orphan, 0, 0);

    // Pause mid-stream.
    pause = 1'b1;
    clear_counts();
    run(100);
    chk("pause_quiet", cnt_mclk + cnt_vdp + cnt_cpu + cnt_psg, 0, 0);
    pause = 1'b0;
    clear_counts();
    run(200);
    chk("post_pause_mclk", cnt_mclk, 100, 100);

    // Reset while a transfer is pending, then the default NTSC rate.
    program_inc(32'h8000_0000);
    step();
    chk("ready_drop", longint'(inc_ready), 0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("ready_after_reset", longint'(inc_ready), 1, 1);
    clear_counts();
    run(74250);
    chk("ntsc_mclk", cnt_mclk, 53692, 53694);
    chk("ntsc_cpu", cnt_cpu, 3578, 3580);
    chk("ntsc_vdp", cnt_vdp, 5368, 5370);

    // inc = 0 stops everything.
    program_inc(32'h0);
    wait_ready("zero_commit", 200);
    step();
    clear_counts();
    run(10000);
    chk("zero_quiet", cnt_mclk + cnt_vdp + cnt_cpu + cnt_psg, 0, 0);

    // Zero never reaches a commit point again, so recover through reset for the max rate.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    program_inc(32'hFFFF_FFFF);
    wait_ready("max_commit", 200);
    step();
    step();
    chk("max_first", longint'(ce_mclk), 1, 1);
    clear_counts();
    run(1000);
    chk("max_mclk", cnt_mclk, 999, 1000);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      reset     = ($urandom % 400) == 0;
      pause     = ($urandom % 16) == 0;
      inc_valid = ($urandom % 8) == 0;
      inc_in    = $urandom_range(32'hFFFF_FFFF, 32'h4000_0000);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
